// File: rtl/uart_rx_cfg_if.sv
// Word handshake between uart_rx_cfg (master) and the command decoder (slave).
// break_det exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_cfg_if;
   logic       data_valid;
   logic       data_ready;
   logic [7:0] byte_data;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;
`ifdef UART_RX_BREAK_DET_EN
   logic       break_det;

   modport master (
      output data_valid, byte_data, parity_err, frame_err, overrun_err, busy, break_det,
      input  data_ready
   );
   modport slave (
      input  data_valid, byte_data, parity_err, frame_err, overrun_err, busy, break_det,
      output data_ready
   );
`else
   modport master (
      output data_valid, byte_data, parity_err, frame_err, overrun_err, busy,
      input  data_ready
   );
   modport slave (
      input  data_valid, byte_data, parity_err, frame_err, overrun_err, busy,
      output data_ready
   );
`endif
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, ready/valid output.
// Optional break detection is built in when UART_RX_BREAK_DET_EN is defined.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low (or, after a break, for a full idle bit)
// START  | validating the start bit; a majority-1 at mid+1 is a false start
// DATA   | shifting DATA_BITS bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling STOP_BITS stop bits; leaves at mid+1 of the last one
// DONE   | one cycle: present the word or flag overrun
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 1250,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx,
   uart_rx_cfg_if.master rx_if
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_MIDM = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] C_MID  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] C_MIDP = CW'(CLKS_PER_BIT / 2 + 1);
   localparam logic [2:0]    C_LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic          C_LAST_STOP = (STOP_BITS == 2);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_AFTER_DATA = (PARITY != 0) ? S_PARITY : S_STOP;

   logic          r_rx_meta;
   logic          r_rx_s;
   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_votes;
   logic [2:0]    r_bit_idx;
   logic          r_stop_idx;
   logic [7:0]    r_shift;
   logic          r_par_bit;
   logic          r_ferr_acc;

   logic          r_valid;
   logic [7:0]    r_byte;
   logic          r_perr;
   logic          r_ferr;
   logic          r_ovr;

   logic          w_maj;
   logic          w_mid_p;
   logic          w_end;
   logic          w_armed;
   logic          w_deliver;
   logic          w_accept;
   logic          w_par_x;
   logic          w_perr_new;

`ifdef UART_RX_BREAK_DET_EN
   logic          r_all_zero;
   logic          r_brk_wait;

   assign w_armed         = ~r_brk_wait;
   assign w_deliver       = (r_state == S_DONE) & ~r_all_zero;
   assign rx_if.break_det = (r_state == S_DONE) & r_all_zero;
`else
   assign w_armed   = 1'b1;
   assign w_deliver = (r_state == S_DONE);
`endif

   // the third vote is the live sample at mid+1
   assign w_maj    = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_rx_s) | (r_votes[1] & r_rx_s);
   assign w_mid_p  = (r_cnt == C_MIDP);
   assign w_end    = (r_cnt == C_LAST);
   assign w_accept = r_valid & rx_if.data_ready;

   always_comb begin
      w_par_x = (^r_shift) ^ r_par_bit;
      if (PARITY == 1)      w_perr_new = ~w_par_x;
      else if (PARITY == 2) w_perr_new = w_par_x;
      else                  w_perr_new = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_votes    <= 2'b11;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_ferr_acc <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         r_all_zero <= 1'b0;
         r_brk_wait <= 1'b0;
`endif
      end else begin
         if (r_state != S_IDLE && r_state != S_DONE) begin
            r_cnt <= w_end ? '0 : r_cnt + CW'(1);
            if (r_cnt == C_MIDM) r_votes[0] <= r_rx_s;
            if (r_cnt == C_MID)  r_votes[1] <= r_rx_s;
         end
         case (r_state)
            S_IDLE: begin
               if (!r_rx_s && w_armed) begin
                  r_state    <= S_START;
                  r_cnt      <= '0;
                  r_shift    <= '0;
                  r_par_bit  <= 1'b0;
                  r_ferr_acc <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                  r_all_zero <= 1'b1;
`endif
               end
            end
            S_START: begin
               if (w_mid_p && w_maj) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (w_end) begin
                  r_state   <= S_DATA;
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (w_mid_p) r_shift[r_bit_idx] <= w_maj;
               if (w_end) begin
                  if (r_bit_idx == C_LAST_BIT) begin
                     r_state    <= S_AFTER_DATA;
                     r_stop_idx <= 1'b0;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
            S_PARITY: begin
               if (w_mid_p) r_par_bit <= w_maj;
               if (w_end) begin
                  r_state    <= S_STOP;
                  r_stop_idx <= 1'b0;
               end
            end
            S_STOP: begin
               if (w_mid_p && !w_maj) r_ferr_acc <= 1'b1;
               // the last stop bit is cut short so a back-to-back start edge is seen
               if (w_mid_p && r_stop_idx == C_LAST_STOP) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
               end else if (w_end) begin
                  r_stop_idx <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
`ifdef UART_RX_BREAK_DET_EN
               if (r_all_zero) r_brk_wait <= 1'b1;
`endif
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
`ifdef UART_RX_BREAK_DET_EN
         if ((r_state == S_DATA || r_state == S_PARITY || r_state == S_STOP) && w_mid_p && w_maj)
            r_all_zero <= 1'b0;
         // after a break, re-arm only once the line has idled for a full bit period
         if (r_state == S_IDLE && r_brk_wait) begin
            if (!r_rx_s) begin
               r_cnt <= '0;
            end else if (w_end) begin
               r_cnt      <= '0;
               r_brk_wait <= 1'b0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_byte  <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (w_deliver) begin
         if (!r_valid || w_accept) begin
            r_valid <= 1'b1;
            r_byte  <= r_shift;
            r_perr  <= w_perr_new;
            r_ferr  <= r_ferr_acc;
            r_ovr   <= 1'b0;
         end else begin
            r_ovr <= 1'b1;
         end
      end else if (w_accept) begin
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end
   end

   assign rx_if.data_valid  = r_valid;
   assign rx_if.byte_data   = r_byte;
   assign rx_if.parity_err  = r_perr;
   assign rx_if.frame_err   = r_ferr;
   assign rx_if.overrun_err = r_ovr;
   assign rx_if.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, directed plus random frames.
module tb_uart_rx_cfg;
   localparam int CPB = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx_a  = 1'b1;
   logic rx_b  = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   t_start = 0;

   always #5 clk = ~clk;

   uart_rx_cfg_if if_a ();
   uart_rx_cfg_if if_b ();

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
      u_a (.clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_if(if_a));
   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
      u_b (.clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_if(if_b));

   // accepted words {parity_err, frame_err, byte}, valid-high cycle counts, rise times
   logic [9:0] q_a[$];
   logic [9:0] q_b[$];
   int   vcyc_a = 0, vcyc_b = 0, rise_a = 0, rise_b = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (if_a.data_valid) begin
         vcyc_a++;
         if (!prev_a) rise_a = cyc;
         if (if_a.data_ready) q_a.push_back({if_a.parity_err, if_a.frame_err, if_a.byte_data});
      end
      prev_a = if_a.data_valid;
   end

   always @(negedge clk) begin
      if (if_b.data_valid) begin
         vcyc_b++;
         if (!prev_b) rise_b = cyc;
         if (if_b.data_ready) q_b.push_back({if_b.parity_err, if_b.frame_err, if_b.byte_data});
      end
      prev_b = if_b.data_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ones(input logic [7:0] d, input int nb);
      int n = 0;
      for (int i = 0; i < nb; i++) n += int'(d[i]);
      return n;
   endfunction

   // parity bit a correct transmitter sends: 1 = odd, 2 = even
   function automatic bit good_par(input logic [7:0] d, input int nb, input int mode);
      if (mode == 2) return (ones(d, nb) % 2) == 1;
      return (ones(d, nb) % 2) == 0;
   endfunction

   function automatic bit ref_perr(input logic [7:0] d, input int nb, input bit p, input int mode);
      int total;
      total = ones(d, nb) + int'(p);
      if (mode == 1) return (total % 2) == 0;
      if (mode == 2) return (total % 2) == 1;
      return 1'b0;
   endfunction

   // sync(2) + IDLE reaction(1), every bit before the last stop, then count mid+1 plus DONE and valid
   function automatic int exp_lat(input int nb, input int par, input int nstop);
      return 3 + (nb + (par != 0 ? 1 : 0) + nstop) * CPB + CPB / 2 + 3;
   endfunction

   task automatic send_frame(input bit sel, input logic [7:0] d, input int nb, input int par,
                             input int nstop, input bit flip_par, input bit stop_val,
                             input int glitch_at, input int cut);
      bit q[$];
      bit lvl;
      q.push_back(1'b0);
      for (int i = 0; i < nb; i++) q.push_back(d[i]);
      if (par != 0) q.push_back(good_par(d, nb, par) ^ flip_par);
      for (int i = 0; i < nstop; i++) q.push_back(stop_val);
      t_start = cyc;
      for (int c = 0; c < q.size() * CPB; c++) begin
         if (cut >= 0 && c >= cut) break;
         lvl = q[c / CPB];
         if (c == glitch_at) lvl = ~lvl;
         if (sel) rx_b = lvl; else rx_a = lvl;
         tick();
      end
      if (sel) rx_b = 1'b1; else rx_a = 1'b1;
   endtask

   task automatic pop_a(output logic [9:0] w);
      if (q_a.size() > 0) w = q_a.pop_front(); else w = 'x;
   endtask

   task automatic pop_b(output logic [9:0] w);
      if (q_b.size() > 0) w = q_b.pop_front(); else w = 'x;
   endtask

   initial begin
      logic [9:0] w;
      logic [7:0] d;
      bit         fl, p;

      if_a.data_ready = 1'b1;
      if_b.data_ready = 1'b1;
      repeat (3) tick();
      chk("rst_a_outs", {if_a.data_valid, if_a.parity_err, if_a.frame_err, if_a.overrun_err,
                         if_a.busy, if_a.byte_data}, 0);
      rst_n = 1'b1;
      repeat (4) tick();

      // 8N1 0xA5, consumer ready
      vcyc_a = 0;
      send_frame(0, 8'hA5, 8, 0, 1, 0, 1, -1, -1);
      repeat (2 * CPB) tick();
      chk("a5_cnt", q_a.size(), 1);
      chk("a5_vcyc", vcyc_a, 1);
      chk("a5_lat", rise_a - t_start, exp_lat(8, 0, 1));
      pop_a(w);
      chk("a5_byte", w[7:0], 8'hA5);
      chk("a5_errs", w[9:8], 2'b00);

      // 7E2: good parity, then flipped parity bit
      send_frame(1, 8'h5A, 7, 2, 2, 0, 1, -1, -1);
      repeat (2 * CPB) tick();
      send_frame(1, 8'h5A, 7, 2, 2, 1, 1, -1, -1);
      repeat (2 * CPB) tick();
      chk("par_cnt", q_b.size(), 2);
      pop_b(w);
      chk("par_good", w, {1'b0, 1'b0, 8'h5A});
      pop_b(w);
      chk("par_bad", w, {1'b1, 1'b0, 8'h5A});

      // 3-cycle low glitch on idle line: false start
      vcyc_a = 0;
      rx_a = 1'b0;
      repeat (3) tick();
      rx_a = 1'b1;
      repeat (3 * CPB) tick();
      chk("glitch_vcyc", vcyc_a, 0);
      chk("glitch_busy", if_a.busy, 0);

      // 0x00 with a one-cycle flip in the middle of data bit 3
      send_frame(0, 8'h00, 8, 0, 1, 0, 1, 4 * CPB + CPB / 2, -1);
      repeat (2 * CPB) tick();
      chk("vote_cnt", q_a.size(), 1);
      pop_a(w);
      chk("vote_word", w, 10'h000);

      // stop bit low on 0x3C
      send_frame(0, 8'h3C, 8, 0, 1, 0, 0, -1, -1);
      repeat (3 * CPB) tick();
      chk("ferr_cnt", q_a.size(), 1);
      pop_a(w);
      chk("ferr_word", w, {1'b0, 1'b1, 8'h3C});

      // overrun: consumer stalled across two back-to-back frames
      if_a.data_ready = 1'b0;
      send_frame(0, 8'h11, 8, 0, 1, 0, 1, -1, -1);
      send_frame(0, 8'h22, 8, 0, 1, 0, 1, -1, -1);
      repeat (CPB) tick();
      chk("ovr_valid", if_a.data_valid, 1);
      chk("ovr_byte", if_a.byte_data, 8'h11);
      chk("ovr_flag", if_a.overrun_err, 1);
      if_a.data_ready = 1'b1;
      tick();
      if_a.data_ready = 1'b0;
      chk("ovr_acc_valid", if_a.data_valid, 0);
      chk("ovr_acc_flag", if_a.overrun_err, 0);
      pop_a(w);
      chk("ovr_acc_byte", w[7:0], 8'h11);
      if_a.data_ready = 1'b1;
      repeat (CPB) tick();

      // reset mid-way through the data bits of 0x77
      q_a.delete();
      send_frame(0, 8'h77, 8, 0, 1, 0, 1, -1, 4 * CPB + 5);
      chk("midrst_busy_pre", if_a.busy, 1);
      rst_n = 1'b0;
      repeat (2) tick();
      chk("midrst_a_outs", {if_a.data_valid, if_a.parity_err, if_a.frame_err, if_a.overrun_err,
                            if_a.busy, if_a.byte_data}, 0);
      chk("midrst_b_outs", {if_b.data_valid, if_b.parity_err, if_b.frame_err, if_b.overrun_err,
                            if_b.busy, if_b.byte_data}, 0);
      rst_n = 1'b1;
      repeat (2 * CPB) tick();
      chk("midrst_nodata", q_a.size(), 0);
      send_frame(0, 8'h88, 8, 0, 1, 0, 1, -1, -1);
      repeat (2 * CPB) tick();
      chk("midrst_cnt", q_a.size(), 1);
      pop_a(w);
      chk("midrst_word", w, {2'b00, 8'h88});

      // random 8N1 words
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom_range(0, 255));
         send_frame(0, d, 8, 0, 1, 0, 1, -1, -1);
         repeat (CPB) tick();
         pop_a(w);
         chk($sformatf("rnd_a%0d", k), w, {2'b00, d});
      end

      // random 7E2 words with random parity corruption
      for (int k = 0; k < 4; k++) begin
         d  = 8'($urandom_range(0, 255));
         fl = 1'($urandom_range(0, 1));
         p  = good_par(d, 7, 2) ^ fl;
         send_frame(1, d, 7, 2, 2, fl, 1, -1, -1);
         if (k == 0) chk("rnd_b_lat", rise_b - t_start, exp_lat(7, 2, 2));
         repeat (CPB) tick();
         pop_b(w);
         chk($sformatf("rnd_b%0d", k), w, {ref_perr(d, 7, p, 2), 1'b0, 1'b0, d[6:0]});
      end

      chk("end_busy", {if_a.busy, if_b.busy}, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
